dts_tx_formatter: RTL
=====================

# dts_tx_formatter

Per-lane DTS transmit framer, the transmit-side counterpart of the DTS receive deformatter. It accepts 128-bit payload words from an upstream FIFO through a valid/ready handshake, plus metaframe timing pulses. It emits one continuous 160-bit frame per clock to a GTY TX gearbox lane. Each frame carries a sync byte, marker flags, payload parity and a 20-bit frame counter that is aligned to the 10 ms metaframe. One instance is placed per transmit lane, in the GTY TX user clock domain.

## Interface
- META_LEN, 625000: frames per metaframe (10 ms at 62.5 MHz); range 2..2^20.
- SYNC_NORM, 8'hA5: sync byte for ordinary frames.
- SYNC_META, 8'h5A: sync byte for the first frame of a metaframe.

- clk  in  1  GTY TX user clock; every frame and register is timed on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 0 forces the ALIGN state.
- index  in  1  one-cycle metaframe-start pulse.
- one_sec  in  1  qualifier for the 1 pps marker; sampled only when index=1.
- ten_sec  in  1  qualifier for the 0.1 pps marker; sampled only when index=1.
- din  in  128  payload word.
- din_valid  in  1  payload word present.
- din_ready  out  1  block accepts din this cycle; equals (state==RUN).
- dout  out  160  frame to the GTY TX.
- locked  out  1  1 while in RUN.
- fill_cnt  out  16  saturating count of fill frames emitted in RUN.
- meta_err_cnt  out  16  saturating count of metaframe misalignments.

## Operation
- Frame layout:
  - dout[159:152]: sync byte.
  - dout[151]: ten_sec flag.
  - dout[150]: one_sec flag.
  - dout[149]: fill flag.
  - dout[148]: parity, the XOR of the 128 payload bits in dout[127:0].
  - dout[147:128]: frame count.
  - dout[127:0]: payload.
- Idle frame: {SYNC_NORM, 4'b0010, 20'd0, 128'd0}.
- States: ALIGN (reset state) and RUN.
- ALIGN:
  - dout is the idle frame every cycle; din_ready=0; locked=0.
  - When index=1 and enable=1, the state moves to RUN at the next edge.
  - The frame registered on that same edge is the first metaframe frame: count 0, sync SYNC_META, flags from one_sec/ten_sec, fill=1, payload 0.
- RUN:
  - Frame count increments by 1 each cycle and wraps from META_LEN-1 to 0.
  - Accepted beat (din_valid & din_ready): payload=din, fill=0.
  - No accepted beat: payload=0, fill=1, and fill_cnt increments.
  - The sync byte is SYNC_META when the count is 0, otherwise SYNC_NORM.
  - The ten_sec and one_sec flags are 1 only on a frame registered while index=1; otherwise they are 0.
- Metaframe alignment in RUN:
  - index=1 while the next count would be nonzero: count is forced to 0, SYNC_META is sent, and meta_err_cnt increments.
  - Count wraps to 0 while index=0: the frame is still count 0 with SYNC_META, and meta_err_cnt increments. The counter free-runs.
  - index=1 exactly at the wrap: correct alignment, no error.
- enable=0 in any state: next state is ALIGN and the next frame is the idle frame. This takes priority over a simultaneous index.
- Counters:
  - fill_cnt and meta_err_cnt saturate at 16'hFFFF.
  - They are cleared only by rst and hold their value across ALIGN.
  - In ALIGN neither counter increments.

## Timing
- All outputs are registered except din_ready, which is decoded from the state register.
- Reset: state=ALIGN, dout=idle frame, locked=0, din_ready=0, fill_cnt=0, meta_err_cnt=0, frame count=0.
- Latency: inputs sampled at edge n appear on dout after edge n, i.e. one cycle. Exactly one frame is emitted per clock with no gaps.
- The first accepted payload after ALIGN→RUN is in frame count 1, because din_ready=0 during the index cycle.
- rst asserted mid-metaframe: the reset values appear after the next edge, and any beat presented that cycle is not accepted.
- Parity is computed combinationally from the selected payload in the same cycle it is registered.

## Test plan
- Reset, then enable=1 with no index for 50 cycles:
  - dout stays {A5,0010,0,0}; din_ready=0; locked=0; both counters 0.
- index pulse in ALIGN with one_sec=1, then din_valid held high with din=i:
  - First frame: sync 5A, flags 0110, count 0.
  - Next frames: count 1,2,… with payload i, fill=0, correct parity.
- META_LEN=16, index every 16 cycles in RUN:
  - count wraps 15→0 with sync 5A on each wrap; meta_err_cnt stays 0.
- META_LEN=16, index 5 cycles early, then index stopped:
  - Early index: count jumps to 0 and meta_err_cnt=1.
  - Each following unindexed wrap increments meta_err_cnt (2, 3, …).
- din_valid toggling 1/0 in RUN for 20 cycles:
  - 10 fill frames (payload 0, fill=1, parity 0); fill_cnt=10; no beat dropped or duplicated.
- Corner cases:
  - enable dropped in the same cycle as index: next frame is idle and the state stays ALIGN.
  - rst mid-RUN: all outputs return to their reset values one edge later.
  - Forcing fill_cnt to FFFF: it stays at FFFF.

Source files
------------

// File: rtl/dts_tx_formatter.sv
// DTS transmit framer: wraps 128-bit payload beats into continuous 160-bit frames
// carrying sync byte, PPS flags, fill flag, payload parity and a metaframe-aligned count.
module dts_tx_formatter #(
    parameter int         META_LEN  = 625000,
    parameter logic [7:0] SYNC_NORM = 8'hA5,
    parameter logic [7:0] SYNC_META = 8'h5A
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         index_i,
    input  logic         one_sec_i,
    input  logic         ten_sec_i,
    input  logic [127:0] din_i,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    output logic [159:0] dout_o,
    output logic         locked_o,
    output logic [15:0]  fill_cnt_o,
    output logic [15:0]  meta_err_cnt_o
);

    typedef enum logic {ALIGN = 1'b0, RUN = 1'b1} state_t;

    localparam logic [159:0] IDLE_FRAME = {SYNC_NORM, 4'b0010, 20'd0, 128'd0};
    localparam logic [19:0]  LAST_CNT   = 20'(META_LEN - 1);

    state_t         state_q, state_d;
    logic [19:0]    cnt_q, cnt_d;
    logic [159:0]   dout_q, dout_d;
    logic           locked_q;
    logic [15:0]    fill_q, fill_d;
    logic [15:0]    err_q, err_d;

    logic           beat;
    logic           wrap;
    logic [127:0]   payload;
    logic [1:0]     flags;
    logic [7:0]     sync;

    assign din_ready_o = (state_q == RUN);
    assign beat        = din_valid_i & din_ready_o;
    assign wrap        = (cnt_q == LAST_CNT);
    assign payload     = beat ? din_i : 128'd0;
    assign flags       = index_i ? {ten_sec_i, one_sec_i} : 2'b00;
    assign sync        = (cnt_d == 20'd0) ? SYNC_META : SYNC_NORM;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = IDLE_FRAME;
        fill_d  = fill_q;
        err_d   = err_q;
        if (!enable_i) begin
            state_d = ALIGN;
            cnt_d   = 20'd0;
        end else if (state_q == ALIGN) begin
            cnt_d = 20'd0;
            if (index_i) begin
                state_d = RUN;
                dout_d  = {SYNC_META, flags, 1'b1, 1'b0, 20'd0, 128'd0};
            end
        end else begin
            // index resynchronises the counter; a mismatch between index and wrap is an error
            cnt_d = (index_i || wrap) ? 20'd0 : cnt_q + 20'd1;
            if ((index_i ^ wrap) && err_q != 16'hFFFF)
                err_d = err_q + 16'd1;
            if (!beat && fill_q != 16'hFFFF)
                fill_d = fill_q + 16'd1;
            dout_d = {sync, flags, ~beat, ^payload, cnt_d, payload};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ALIGN;
            cnt_q    <= 20'd0;
            dout_q   <= IDLE_FRAME;
            locked_q <= 1'b0;
            fill_q   <= 16'd0;
            err_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            locked_q <= (state_d == RUN);
            fill_q   <= fill_d;
            err_q    <= err_d;
        end
    end

    assign dout_o         = dout_q;
    assign locked_o       = locked_q;
    assign fill_cnt_o     = fill_q;
    assign meta_err_cnt_o = err_q;

endmodule
